// File: rtl/hub75_bcm_scanner.sv
// HUB75 panel scanner: fetches one column across all lanes, shifts one bit-plane per pass,
// then latches the row and lights it for a binary-weighted OE window.
module hub75_bcm_scanner #(
    parameter int COLS     = 64,
    parameter int ROWS     = 32,
    parameter int CHANNELS = 2,
    parameter int BPC      = 8,
    parameter int CLK_DIV  = 2,
    parameter int OE_BASE  = 8,
    localparam int SCAN    = ROWS / CHANNELS,
    localparam int AW      = $clog2(ROWS * COLS),
    localparam int RW      = (SCAN > 1) ? $clog2(SCAN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [3*BPC-1:0]      mem_rd_data,
    output logic [3*CHANNELS-1:0] hub_rgb,
    output logic                  hub_sclk,
    output logic                  hub_lat,
    output logic                  hub_oe_n,
    output logic [RW-1:0]         hub_addr,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW  = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int OW  = $clog2(OE_BASE << (BPC - 1)) + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_CAPTURE  = 3'd2;
    localparam logic [2:0] S_SHIFT_LO = 3'd3;
    localparam logic [2:0] S_SHIFT_HI = 3'd4;
    localparam logic [2:0] S_WAIT_OE  = 3'd5;
    localparam logic [2:0] S_LATCH    = 3'd6;

    logic [2:0]            state;
    logic [CHW-1:0]        ch_idx;
    logic [CW-1:0]         col;
    logic [DW-1:0]         div_cnt;
    logic [RW-1:0]         row;
    logic [PW-1:0]         plane;
    logic [OW-1:0]         oe_cnt;
    logic [2:0]            lane_bits [CHANNELS];
    logic [2:0]            plane_bits;
    logic [3*CHANNELS-1:0] rgb_next;
    logic                  last_plane;
    logic                  last_row;

    assign last_plane = (plane == PW'(BPC - 1));
    assign last_row   = (row == RW'(SCAN - 1));

    // Selected bit-plane of the word arriving this cycle, packed {b,g,r}.
    always_comb begin
        plane_bits    = '0;
        plane_bits[0] = |((mem_rd_data[BPC-1:0]       >> plane) & BPC'(1));
        plane_bits[1] = |((mem_rd_data[2*BPC-1:BPC]   >> plane) & BPC'(1));
        plane_bits[2] = |((mem_rd_data[3*BPC-1:2*BPC] >> plane) & BPC'(1));
    end

    // The last lane's word arrives during CAPTURE, so it bypasses the lane buffer.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign rgb_next[3*c +: 3] = (c == CHANNELS - 1) ? plane_bits : lane_bits[c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ch_idx    <= '0;
            col       <= '0;
            div_cnt   <= '0;
            row       <= '0;
            plane     <= '0;
            oe_cnt    <= '0;
            lane_bits <= '{default: '0};
            hub_rgb   <= '0;
            hub_addr  <= '0;
            hub_oe_n  <= 1'b1;
        end else begin
            // OE window of the latched plane runs alongside shifting of the next one.
            if (state == S_LATCH) begin
                hub_oe_n <= 1'b0;
                oe_cnt   <= (OW'(OE_BASE) << plane) - 1'b1;
            end else if (!hub_oe_n) begin
                if (oe_cnt == '0) begin
                    hub_oe_n <= 1'b1;
                end else begin
                    oe_cnt <= oe_cnt - 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state  <= S_FETCH;
                        row    <= '0;
                        plane  <= '0;
                        col    <= '0;
                        ch_idx <= '0;
                    end
                end
                S_FETCH: begin
                    if (ch_idx != '0) begin
                        lane_bits[ch_idx - 1'b1] <= plane_bits;
                    end
                    if (ch_idx == CHW'(CHANNELS - 1)) begin
                        ch_idx <= '0;
                        state  <= S_CAPTURE;
                    end else begin
                        ch_idx <= ch_idx + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    hub_rgb <= rgb_next;
                    div_cnt <= '0;
                    state   <= S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        state   <= S_SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_SHIFT_HI: begin
                    if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (col == CW'(COLS - 1)) begin
                            col   <= '0;
                            state <= S_WAIT_OE;
                        end else begin
                            col   <= col + 1'b1;
                            state <= S_FETCH;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_WAIT_OE: begin
                    if (hub_oe_n) begin
                        hub_addr <= row;
                        state    <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (last_plane) begin
                        plane <= '0;
                        row   <= last_row ? '0 : row + 1'b1;
                    end else begin
                        plane <= plane + 1'b1;
                    end
                    state <= (last_plane && last_row && !enable) ? S_IDLE : S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_en   = (state == S_FETCH);
    assign mem_rd_addr = mem_rd_en ? AW'((32'(ch_idx) * SCAN + 32'(row)) * COLS + 32'(col)) : '0;
    assign hub_sclk    = (state == S_SHIFT_HI);
    assign hub_lat     = (state == S_LATCH);
    assign frame_done  = hub_lat && last_plane && last_row;
    assign busy        = (state != S_IDLE) || !hub_oe_n;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Self-checking bench for hub75_bcm_scanner: panel-pin event logs compared with a
// frame-level model computed from the memory contents.
module tb_hub75_bcm_scanner;

    localparam int COLS    = 4;
    localparam int ROWS    = 4;
    localparam int CHN     = 2;
    localparam int BPC     = 2;
    localparam int CLK_DIV = 1;
    localparam int OE_BASE = 4;
    localparam int SCAN    = ROWS / CHN;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic       mem_rd_en;
    logic [3:0] mem_rd_addr;
    logic [5:0] mem_rd_data;
    logic [5:0] hub_rgb;
    logic       hub_sclk, hub_lat, hub_oe_n, busy, frame_done;
    logic [0:0] hub_addr;

    logic [5:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    // Event logs filled by the pin monitor
    logic [3:0] rd_addr_q [$];
    int         rd_cyc_q  [$];
    logic [5:0] sclk_q    [$];
    int         sclk_cyc_q[$];
    int         oe_q      [$];
    logic [0:0] lat_q     [$];
    logic       fd_q      [$];
    int         viol_lat_oe, viol_oe_start, viol_addr, viol_rgb, viol_fd;

    int         cyc = 0;
    int         oe_len = 0;
    logic [0:0] oe_addr = '0;
    logic       prev_sclk = 1'b0, prev_oe_n = 1'b1, prev_lat = 1'b0;
    logic [5:0] prev_rgb = '0;

    hub75_bcm_scanner #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .CHANNELS(CHN),
        .BPC     (BPC),
        .CLK_DIV (CLK_DIV),
        .OE_BASE (OE_BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .hub_rgb    (hub_rgb),
        .hub_sclk   (hub_sclk),
        .hub_lat    (hub_lat),
        .hub_oe_n   (hub_oe_n),
        .hub_addr   (hub_addr),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous-read frame memory
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sclk = 1'b0;
            prev_oe_n = 1'b1;
            prev_lat  = 1'b0;
            oe_len    = 0;
        end else begin
            if (mem_rd_en) begin
                rd_addr_q.push_back(mem_rd_addr);
                rd_cyc_q.push_back(cyc);
            end
            if (hub_sclk && !prev_sclk) begin
                sclk_q.push_back(hub_rgb);
                sclk_cyc_q.push_back(cyc);
            end
            if (hub_sclk && hub_rgb !== prev_rgb) viol_rgb++;
            if (hub_lat) begin
                lat_q.push_back(hub_addr);
                fd_q.push_back(frame_done);
                if (!hub_oe_n) viol_lat_oe++;
            end else if (frame_done) begin
                viol_fd++;
            end
            if (!hub_oe_n) begin
                if (prev_oe_n) begin
                    if (!prev_lat) viol_oe_start++;
                    oe_addr = hub_addr;
                    oe_len  = 0;
                end else if (hub_addr !== oe_addr) begin
                    viol_addr++;
                end
                oe_len++;
            end else if (!prev_oe_n) begin
                oe_q.push_back(oe_len);
            end
            prev_sclk = hub_sclk;
            prev_oe_n = hub_oe_n;
            prev_lat  = hub_lat;
        end
        prev_rgb = hub_rgb;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void clear_logs();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        sclk_q.delete();
        sclk_cyc_q.delete();
        oe_q.delete();
        lat_q.delete();
        fd_q.delete();
        viol_lat_oe   = 0;
        viol_oe_start = 0;
        viol_addr     = 0;
        viol_rgb      = 0;
        viol_fd       = 0;
    endfunction

    // Lane ch carries bit p of {b,g,r} of pixel (lane row block ch, row r, column c).
    function automatic logic [5:0] exp_rgb(input int r, input int p, input int c);
        logic [5:0] v;
        logic [5:0] w;
        v = '0;
        for (int ch = 0; ch < CHN; ch++) begin
            w = mem[(ch * SCAN + r) * COLS + c];
            for (int k = 0; k < 3; k++) v[3 * ch + k] = w[k * BPC + p];
        end
        return v;
    endfunction

    task automatic check_frames(input int nf);
        int kr, ks, kl;
        kr = 0; ks = 0; kl = 0;
        check("rd_count", rd_addr_q.size(), nf * SCAN * BPC * COLS * CHN);
        check("sclk_count", sclk_q.size(), nf * SCAN * BPC * COLS);
        check("lat_count", lat_q.size(), nf * SCAN * BPC);
        check("oe_count", oe_q.size(), nf * SCAN * BPC);
        for (int f = 0; f < nf; f++)
            for (int r = 0; r < SCAN; r++)
                for (int p = 0; p < BPC; p++) begin
                    for (int c = 0; c < COLS; c++) begin
                        for (int ch = 0; ch < CHN; ch++) begin
                            if (kr < rd_addr_q.size())
                                check("rd_addr", rd_addr_q[kr], (ch * SCAN + r) * COLS + c);
                            kr++;
                        end
                        if (ks < sclk_q.size()) check("rgb_at_sclk", sclk_q[ks], exp_rgb(r, p, c));
                        ks++;
                    end
                    if (kl < lat_q.size()) begin
                        check("lat_row_addr", lat_q[kl], r);
                        check("frame_done_at_lat", fd_q[kl], (r == SCAN - 1 && p == BPC - 1) ? 1 : 0);
                    end
                    if (kl < oe_q.size()) check("oe_width", oe_q[kl], OE_BASE << p);
                    kl++;
                end
        check("lat_during_oe", viol_lat_oe, 0);
        check("oe_not_after_lat", viol_oe_start, 0);
        check("addr_change_in_oe", viol_addr, 0);
        check("rgb_change_sclk_hi", viol_rgb, 0);
        check("frame_done_stray", viol_fd, 0);
    endtask

    task automatic wait_first_read(input string tag);
        int n;
        n = 0;
        while (rd_addr_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
        check({tag, "_read_timeout"}, 32'(n < 200), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        check({tag, "_idle_timeout"}, 32'(n < 2000), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_frame_done(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check({tag, "_frame_done_timeout"}, 32'(n < 2000), 1);
        @(negedge clk);
    endtask

    initial begin
        mem_rd_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = (i < 8) ? 6'b00_00_01 : 6'b00_10_00;
        clear_logs();
        repeat (3) @(negedge clk);

        check("rst_oe_n", hub_oe_n, 1);
        check("rst_sclk", hub_sclk, 0);
        check("rst_lat", hub_lat, 0);
        check("rst_rgb", hub_rgb, 0);
        check("rst_addr", hub_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_rd_en", mem_rd_en, 0);

        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_no_reads", rd_addr_q.size(), 0);
        check("idle_busy", busy, 0);

        // Directed frame; enable dropped once the frame is under way
        clear_logs();
        enable = 1'b1;
        wait_first_read("dir");
        enable = 1'b0;
        wait_idle("dir");
        for (int i = 0; i < 4; i++) if (i < sclk_q.size()) check("dir_plane0_rgb", sclk_q[i], 6'b000_001);
        for (int i = 4; i < 8; i++) if (i < sclk_q.size()) check("dir_plane1_rgb", sclk_q[i], 6'b010_000);
        if (rd_cyc_q.size() > 2 && sclk_cyc_q.size() > 0) begin
            check("rd0_addr", rd_addr_q[0], 0);
            check("rd1_cycle", rd_cyc_q[1] - rd_cyc_q[0], 1);
            check("rd1_addr", rd_addr_q[1], 8);
            check("sclk_rise_cycle", sclk_cyc_q[0] - rd_cyc_q[0], 4);
            check("col_period", rd_cyc_q[2] - rd_cyc_q[0], 5);
            check("rd2_addr", rd_addr_q[2], 1);
        end else begin
            check("dir_log_length", 0, 1);
        end
        if (oe_q.size() == 4) begin
            check("oe_w0", oe_q[0], 4);
            check("oe_w1", oe_q[1], 8);
            check("oe_w2", oe_q[2], 4);
            check("oe_w3", oe_q[3], 8);
        end
        if (lat_q.size() == 4) begin
            check("lat_addr_seq", {lat_q[0], lat_q[1], lat_q[2], lat_q[3]}, 4'b0011);
            check("frame_done_seq", {fd_q[0], fd_q[1], fd_q[2], fd_q[3]}, 4'b0001);
        end
        check_frames(1);
        check("dir_busy_end", busy, 0);

        // Random images, two back-to-back frames each
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 16; i++) mem[i] = 6'($urandom);
            clear_logs();
            enable = 1'b1;
            wait_frame_done("rnd");
            enable = 1'b0;
            wait_idle("rnd");
            check_frames(2);
        end

        // Asynchronous reset while sclk is high
        for (int i = 0; i < 16; i++) mem[i] = 6'($urandom);
        enable = 1'b1;
        begin
            int n;
            n = 0;
            while (hub_sclk !== 1'b1 && n < 200) begin @(negedge clk); n++; end
            check("sclk_hi_timeout", 32'(n < 200), 1);
        end
        #1 rst_n = 1'b0;
        #1;
        check("arst_sclk", hub_sclk, 0);
        check("arst_oe_n", hub_oe_n, 1);
        check("arst_rgb", hub_rgb, 0);
        check("arst_busy", busy, 0);
        check("arst_rd_en", mem_rd_en, 0);
        check("arst_addr", hub_addr, 0);
        @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        wait_first_read("post_rst");
        enable = 1'b0;
        if (rd_addr_q.size() > 0) check("post_rst_first_addr", rd_addr_q[0], 0);
        wait_idle("post_rst");
        check_frames(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
